deser_queue_param: RTL and testbench

Parametrised successor to the serial-in/queue top level. Assembles a WIDTH-bit word from slow serial strobes (data_in sampled on each write_in pulse) and holds it until enqueue_in pushes it into a DEPTH-entry circular FIFO. dequeue_in pops the head word to data_out. Adds parametrised width and depth, bit-order mode, occupancy and full/empty outputs, and sticky overflow/underflow flags. Sits directly behind the board switches and buttons, all on the 1 MHz clock.

---
 rtl/deser_queue_param_if.sv | 27 ++
 rtl/deser_queue_param.sv | 124 ++++++++++++
 tb/tb_deser_queue_param.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/deser_queue_param_if.sv
// rtl/deser_queue_param_if.sv - button/serial inputs and queue status bundle for deser_queue_param
interface deser_queue_param_if #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
);
   logic                       data_in;
   logic                       write_in;
   logic                       enqueue_in;
   logic                       dequeue_in;
   logic                       status_out;
   logic [WIDTH-1:0]           data_out;
   logic [$clog2(DEPTH+1)-1:0] count_out;
   logic                       full_out;
   logic                       empty_out;
   logic                       ovf_err;
   logic                       udf_err;

   modport master (
      output data_in, write_in, enqueue_in, dequeue_in,
      input  status_out, data_out, count_out, full_out, empty_out, ovf_err, udf_err
   );

   modport slave (
      input  data_in, write_in, enqueue_in, dequeue_in,
      output status_out, data_out, count_out, full_out, empty_out, ovf_err, udf_err
   );
endinterface

// File: rtl/deser_queue_param.sv
// rtl/deser_queue_param.sv - serial bit assembler feeding a parametrised circular FIFO
module deser_queue_param #(
   parameter int WIDTH     = 8,
   parameter int DEPTH     = 8,
   parameter int MSB_FIRST = 0
) (
   input logic               clock_1MHz,
   input logic               rst,
   deser_queue_param_if.slave bus
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int PW = $clog2(DEPTH);
   localparam int NW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
   localparam logic [NW-1:0] FULL_CNT = NW'(DEPTH);

   typedef enum logic {ST_RX = 1'b0, ST_HOLD = 1'b1} state_t;

   // sync bit order: {dequeue, enqueue, write, data}
   logic [3:0] sync1, sync2;
   logic [2:0] prev;
   logic       din, wr_pulse, enq_pulse, deq_pulse;

   state_t           state_q, state_d;
   logic             do_enq, deq_ok, ovf_set;
   logic [CW-1:0]    bit_cnt, bit_idx;
   logic [WIDTH-1:0] shift_q, data_q;
   logic [PW-1:0]    rd_ptr, wr_ptr;
   logic [NW-1:0]    count;
   logic             full, empty, ovf_q, udf_q;
   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clock_1MHz) begin
      if (!rst) begin
         sync1 <= '0;
         sync2 <= '0;
         prev  <= '0;
      end else begin
         sync1 <= {bus.dequeue_in, bus.enqueue_in, bus.write_in, bus.data_in};
         sync2 <= sync1;
         prev  <= sync2[3:1];
      end
   end

   assign din       = sync2[0];
   assign wr_pulse  = sync2[1] & ~prev[0];
   assign enq_pulse = sync2[2] & ~prev[1];
   assign deq_pulse = sync2[3] & ~prev[2];

   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign deq_ok  = deq_pulse & ~empty;
   assign bit_idx = (MSB_FIRST != 0) ? (LAST_BIT - bit_cnt) : bit_cnt;

   always_ff @(posedge clock_1MHz) begin
      if (!rst) state_q <= ST_RX;
      else      state_q <= state_d;
   end

   // A same-cycle dequeue frees the slot, so a full FIFO still accepts the held word
   always_comb begin
      state_d = state_q;
      do_enq  = 1'b0;
      ovf_set = 1'b0;
      case (state_q)
         ST_RX: begin
            if (wr_pulse && bit_cnt == LAST_BIT) state_d = ST_HOLD;
         end
         ST_HOLD: begin
            if (enq_pulse) begin
               if (!full || deq_ok) begin
                  do_enq  = 1'b1;
                  state_d = ST_RX;
               end else begin
                  ovf_set = 1'b1;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clock_1MHz) begin
      if (!rst) begin
         bit_cnt <= '0;
         shift_q <= '0;
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         count   <= '0;
         data_q  <= '0;
         ovf_q   <= 1'b0;
         udf_q   <= 1'b0;
      end else begin
         if (state_q == ST_RX && wr_pulse) begin
            shift_q[bit_idx] <= din;
            bit_cnt          <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + CW'(1);
         end
         if (do_enq) begin
            shift_q <= '0;
            wr_ptr  <= wr_ptr + PW'(1);
         end
         if (deq_ok) begin
            data_q <= mem[rd_ptr];
            rd_ptr <= rd_ptr + PW'(1);
         end
         if (do_enq && !deq_ok)      count <= count + NW'(1);
         else if (!do_enq && deq_ok) count <= count - NW'(1);
         if (ovf_set)             ovf_q <= 1'b1;
         if (deq_pulse && empty)  udf_q <= 1'b1;
      end
   end

   // Storage is left uninitialised; only the pointers and count define validity
   always_ff @(posedge clock_1MHz) begin
      if (rst && do_enq) mem[wr_ptr] <= shift_q;
   end

   assign bus.status_out = (state_q == ST_RX);
   assign bus.data_out   = data_q;
   assign bus.count_out  = count;
   assign bus.full_out   = full;
   assign bus.empty_out  = empty;
   assign bus.ovf_err    = ovf_q;
   assign bus.udf_err    = udf_q;
endmodule

// File: tb/tb_deser_queue_param.sv
// tb/tb_deser_queue_param.sv - checks both bit orders of deser_queue_param against a queue model
`timescale 1ns/1ps
module tb_deser_queue_param;
   localparam int W = 8;
   localparam int D = 8;

   logic clk = 1'b0;
   logic rst;
   always #500 clk = ~clk;

   deser_queue_param_if #(.WIDTH(W), .DEPTH(D)) if0 ();
   deser_queue_param_if #(.WIDTH(W), .DEPTH(D)) if1 ();

   assign if1.data_in    = if0.data_in;
   assign if1.write_in   = if0.write_in;
   assign if1.enqueue_in = if0.enqueue_in;
   assign if1.dequeue_in = if0.dequeue_in;

   deser_queue_param #(.WIDTH(W), .DEPTH(D), .MSB_FIRST(0)) dut0 (
      .clock_1MHz(clk), .rst(rst), .bus(if0.slave));
   deser_queue_param #(.WIDTH(W), .DEPTH(D), .MSB_FIRST(1)) dut1 (
      .clock_1MHz(clk), .rst(rst), .bus(if1.slave));

   int errors = 0;
   int checks = 0;

   // reference model: q0/w0 for LSB-first, q1/w1 for MSB-first
   logic [W-1:0] q0[$], q1[$];
   logic [W-1:0] w0, w1, dout0, dout1;
   int           nbits;
   bit           hold, ovf, udf;

   function automatic void m_reset();
      q0.delete(); q1.delete();
      w0 = '0; w1 = '0; dout0 = '0; dout1 = '0;
      nbits = 0; hold = 0; ovf = 0; udf = 0;
   endfunction

   function automatic void m_bit(bit b);
      if (!hold) begin
         w0[nbits] = b;
         w1[W-1-nbits] = b;
         nbits++;
         if (nbits == W) begin
            hold = 1;
            nbits = 0;
         end
      end
   endfunction

   function automatic void m_ops(bit e, bit d);
      bit can_deq, can_enq;
      can_deq = d && (q0.size() > 0);
      can_enq = e && hold && ((q0.size() < D) || can_deq);
      if (d && !can_deq) udf = 1;
      if (e && hold && !can_enq) ovf = 1;
      if (can_deq) begin
         dout0 = q0.pop_front();
         dout1 = q1.pop_front();
      end
      if (can_enq) begin
         q0.push_back(w0);
         q1.push_back(w1);
         w0 = '0; w1 = '0; hold = 0;
      end
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".status0"}, 32'(if0.status_out), 32'(!hold));
      check({tag, ".status1"}, 32'(if1.status_out), 32'(!hold));
      check({tag, ".count0"},  32'(if0.count_out),  32'(q0.size()));
      check({tag, ".count1"},  32'(if1.count_out),  32'(q1.size()));
      check({tag, ".full"},    32'(if0.full_out),   32'(q0.size() == D));
      check({tag, ".empty"},   32'(if0.empty_out),  32'(q0.size() == 0));
      check({tag, ".ovf"},     32'(if0.ovf_err),    32'(ovf));
      check({tag, ".udf"},     32'(if1.udf_err),    32'(udf));
      check({tag, ".dout0"},   32'(if0.data_out),   32'(dout0));
      check({tag, ".dout1"},   32'(if1.data_out),   32'(dout1));
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit w, input bit e, input bit d, input bit b, input int hold_cyc);
      if0.data_in = b; if0.write_in = w; if0.enqueue_in = e; if0.dequeue_in = d;
      tick(hold_cyc);
      if0.data_in = 0; if0.write_in = 0; if0.enqueue_in = 0; if0.dequeue_in = 0;
      tick(3);
   endtask

   task automatic do_bit(input bit b, input int hold_cyc);
      drive(1, 0, 0, b, hold_cyc);
      m_bit(b);
   endtask

   task automatic do_op(input bit e, input bit d);
      drive(0, e, d, 0, 3);
      m_ops(e, d);
   endtask

   task automatic send_word(input logic [W-1:0] v);
      for (int i = 0; i < W; i++) do_bit(v[i], 3);
   endtask

   initial begin
      logic [W-1:0] v;
      int op, base;
      rst = 0;
      if0.data_in = 0; if0.write_in = 0; if0.enqueue_in = 0; if0.dequeue_in = 0;
      m_reset();
      tick(3);
      rst = 1;
      tick(1);
      check_all("reset");

      // 1,0,0,1,1,0,0,1 in time order; status falls on the 8th pulse edge
      v = 8'h99;
      for (int i = 0; i < W - 1; i++) do_bit(v[i], 3);
      if0.data_in = 1; if0.write_in = 1;
      tick(2);
      check("bit8_before", 32'(if0.status_out), 32'd1);
      tick(1);
      check("bit8_edge", 32'(if0.status_out), 32'd0);
      if0.data_in = 0; if0.write_in = 0;
      tick(3);
      m_bit(1);
      check_all("word99");
      do_op(1, 0);
      check_all("enq99");
      do_op(0, 1);
      check("dout_99", 32'(if0.data_out), 32'h99);
      check_all("deq99");

      send_word(8'h03);
      do_op(1, 0);
      do_op(0, 1);
      check("order_lsb", 32'(if0.data_out), 32'h03);
      check("order_msb", 32'(if1.data_out), 32'hC0);
      check_all("order");

      for (int k = 1; k <= D; k++) begin
         send_word(W'(k));
         do_op(1, 0);
      end
      check("fill_full", 32'(if0.full_out), 32'd1);
      check_all("fill");
      send_word(8'd9);
      do_op(1, 0);
      check("ovf_set", 32'(if0.ovf_err), 32'd1);
      check("ovf_hold", 32'(if0.status_out), 32'd0);
      check_all("ovf");
      for (int k = 1; k <= 3; k++) begin
         do_op(0, 1);
         check("deq_head", 32'(if0.data_out), 32'(k));
      end
      do_op(1, 0);
      send_word(8'd10); do_op(1, 0);
      send_word(8'd11); do_op(1, 0);
      check("wrap_count", 32'(if0.count_out), 32'd8);
      check_all("wrap");
      for (int k = 4; k <= 11; k++) begin
         do_op(0, 1);
         check("wrap_order", 32'(if0.data_out), 32'(k));
      end
      do_op(0, 1);
      check("udf_set", 32'(if0.udf_err), 32'd1);
      check("udf_keep", 32'(if0.data_out), 32'd11);
      check_all("underflow");

      do_bit(1, 3); do_bit(0, 3); do_bit(1, 3);
      rst = 0;
      tick(1);
      rst = 1;
      m_reset();
      check_all("mid_reset");
      send_word(8'hA5);
      do_op(1, 0);
      do_op(0, 1);
      check("dout_a5", 32'(if0.data_out), 32'hA5);
      check_all("after_reset");

      // a 10-cycle held write must contribute one bit only
      do_bit(1, 10);
      for (int i = 1; i < W; i++) do_bit(0, 3);
      do_op(1, 0);
      do_op(0, 1);
      check_all("held_write");

      send_word(8'h3C);
      base = q0.size();
      if0.enqueue_in = 1;
      tick(1);
      check("enq_k", 32'(if0.count_out), 32'(base));
      tick(1);
      check("enq_k1", 32'(if0.count_out), 32'(base));
      tick(1);
      check("enq_k2", 32'(if0.count_out), 32'(base + 1));
      if0.enqueue_in = 0;
      tick(3);
      m_ops(1, 0);
      check_all("enq_timing");

      while (q0.size() < D) begin
         send_word(W'($urandom));
         do_op(1, 0);
      end
      send_word(W'($urandom));
      do_op(1, 1);
      check("both_full_cnt", 32'(if0.count_out), 32'd8);
      check("both_full_ovf", 32'(if0.ovf_err), 32'd0);
      check_all("both_full");

      for (int n = 0; n < 80; n++) begin
         op = int'($urandom_range(0, 5));
         case (op)
            0, 1:    do_bit(1'($urandom), 3);
            2:       do_op(1, 0);
            3:       do_op(0, 1);
            default: do_op(1, 1);
         endcase
         check_all("random");
      end
      for (int n = 0; n <= D; n++) begin
         do_op(0, 1);
         check_all("drain");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
